// File: rtl/ttl_74169_preload_ctrl.sv
// Preload controller for a cascaded 74169 counter chain.
// Shadows CPU byte writes and holds load_n low until the counters' cen edge latches P.
module ttl_74169_preload_ctrl #(
    parameter int WIDTH       = 12,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             cen,
    input  logic             cpu_wr_lo,
    input  logic             cpu_wr_hi,
    input  logic [7:0]       cpu_din,
    input  logic             line_start,
    output logic             load_n,
    output logic [WIDTH-1:0] P,
    output logic             pending,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shadow;
    logic             last_cen;
    logic             cen_rise;
    logic             arm;
    logic             unused_din;

    // Upper cpu_din bits are dropped on hi writes for narrow chains.
    assign unused_din = ^cpu_din;

    assign cen_rise = cen & ~last_cen;
    assign arm      = (state == IDLE) & line_start & (pending | AUTO_RELOAD);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load_n   = 1'b1;
        busy     = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm) state_nx = ARMED;
            end
            ARMED: begin
                load_n = 1'b0;
                busy   = 1'b1;
                if (cen_rise) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Held at 1 through reset so a cen already high is not seen as an edge.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_cen <= 1'b1;
        end else begin
            last_cen <= cen;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow <= '0;
        end else begin
            if (cpu_wr_lo) shadow[7:0] <= cpu_din;
            if (cpu_wr_hi) shadow[WIDTH-1:8] <= cpu_din[WIDTH-9:0];
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            P <= '0;
        end else if (arm) begin
            P <= shadow;
        end
    end

    // A hi write in the arming clk marks the new value for the next line.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending <= 1'b0;
        end else if (cpu_wr_hi) begin
            pending <= 1'b1;
        end else if (arm) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            overrun <= 1'b0;
        end else if (line_start && (state == ARMED)) begin
            overrun <= 1'b1;
        end else if (cpu_wr_hi) begin
            overrun <= 1'b0;
        end
    end

endmodule
